imem_banked_loader: RTL

Parametrised banked instruction memory, the next generation of the CPU's four-bank IMEM. It is generalised in word width, bank count and bank depth, and any subset of banks can be marked read-only. It adds a registered read port, a protected direct write port, and a streaming bulk-load engine with a valid/ready handshake, used by the boot/programming path to fill program memory before the CPU is released.

---
 rtl/imem_banked_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imem_banked_loader.sv
// Banked instruction memory with per-bank write protection, a registered
// read port, a direct write port and a valid/ready bulk-load engine that
// the boot path uses to fill program memory before the CPU is released.
module imem_banked_loader #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    NUM_BANKS    = 4,
    parameter int                    BANK_DEPTH   = 16,
    parameter logic [NUM_BANKS-1:0]  RO_BANK_MASK = 4'b0011,
    localparam int                   BANK_W       = $clog2(NUM_BANKS),
    localparam int                   ADDR_W       = BANK_W + $clog2(BANK_DEPTH)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  RoUnlock,
    input  logic                  ReadEnable,
    input  logic [ADDR_W-1:0]     ReadAddr,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    input  logic                  WriteEnable,
    input  logic [ADDR_W-1:0]     WriteAddr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  LoadStart,
    input  logic [ADDR_W-1:0]     LoadBase,
    input  logic [ADDR_W:0]       LoadCount,
    input  logic                  LoadValid,
    input  logic [DATA_WIDTH-1:0] LoadData,
    output logic                  LoadReady,
    output logic                  LoadBusy,
    output logic                  LoadDone,
    output logic                  WriteError
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS*BANK_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W:0]       remain_q, remain_d;

    // Single internal write port: direct writes own it in IDLE, the loader in LOAD.
    logic                  wr_req;
    logic                  wr_ro;
    logic                  wr_go;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  err_d;

    // Next-state, write-port steering and write-rejection decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        wr_req   = 1'b0;
        wr_addr  = WriteAddr;
        wr_data  = WriteData;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                wr_req = WriteEnable;
                if (LoadStart) begin
                    addr_d   = LoadBase;
                    remain_d = LoadCount;
                    state_d  = (LoadCount == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                // A direct write while the engine owns the port is dropped and flagged.
                err_d = WriteEnable;
                if (LoadValid) begin
                    wr_req   = 1'b1;
                    wr_addr  = addr_q;
                    wr_data  = LoadData;
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                err_d   = WriteEnable;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Protected banks only take writes while boot programming unlocks them;
        // a rejected load word still counts as consumed.
        wr_ro = RO_BANK_MASK[wr_addr[ADDR_W-1 -: BANK_W]] && !RoUnlock;
        wr_go = wr_req && !wr_ro && Reset;
        if (wr_req && wr_ro) begin
            err_d = 1'b1;
        end
    end

    // Loader control state and the write-error pulse.
    always_ff @(posedge Clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!Reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            WriteError <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            WriteError <= err_d;
        end
    end

    // Storage array write.
    always_ff @(posedge Clock) begin
        // NOTE: the array has no reset; program contents must survive a control reset.
        if (wr_go) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read-before-write port; data holds when no read is requested.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ReadData  <= '0;
            ReadValid <= 1'b0;
        end else begin
            ReadValid <= ReadEnable;
            if (ReadEnable) begin
                ReadData <= mem[ReadAddr];
            end
        end
    end

    assign LoadReady = (state_q == LOAD);
    assign LoadBusy  = (state_q != IDLE);
    assign LoadDone  = (state_q == DONE);

endmodule
